// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and constants for the serial pattern scan controller.
package seq_ctrl_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Byte-stream valid/ready channel feeding the scan controller.
interface seq_scan_ctrl_if;
    import seq_ctrl_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/seq_scan_ctrl_match.sv
// History shift register, fill counter and length-masked pattern comparator.
module seq_match
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             match_o,
    output logic             det_pulse_o
);

    logic [PAT_W-1:0] hist_q, hist_nxt;
    logic [LEN_W-1:0] fill_q, fill_nxt;
    logic [PAT_W-1:0] mask;
    logic             det_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end
    end

    assign hist_nxt = {hist_q[PAT_W-2:0], bit_i};
    assign fill_nxt = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;

    // Compared against the post-shift history so the FSM sees this bit's match now.
    assign match_o = shift_en_i && (len_i != '0) && (fill_nxt >= len_i) &&
                     (((hist_nxt ^ pat_i) & mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else if (clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            det_q <= match_o;
            if (shift_en_i) begin
                hist_q <= hist_nxt;
                fill_q <= fill_nxt;
            end
        end
    end

    assign det_pulse_o = det_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: serialises accepted bytes MSB-first into seq_match and counts matches.
module seq_scan_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_clr,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    seq_scan_ctrl_if.slave   in_if,
    output logic             det_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    localparam int IDX_W = $clog2(BYTE_W);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic              irq_q, irq_d;

    logic start_acc, shift_en, match, thresh_hit, ready;

    assign start_acc = (state_q == IDLE) && start;
    assign shift_en  = (state_q == SHIFT);

    seq_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_acc),
        .shift_en_i  (shift_en),
        .bit_i       (byte_q[bit_idx_q]),
        .pat_i       (pat_q),
        .len_i       (len_q),
        .match_o     (match),
        .det_pulse_o (det_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            bit_idx_q   <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            thresh_q    <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            bit_idx_q   <= bit_idx_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            thresh_q    <= thresh_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Uses the count including the current bit, so a threshold hit on bit 0 still ends the scan.
    assign thresh_hit = (thresh_q != '0) && (cnt_d >= thresh_q);

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        bit_idx_d   = bit_idx_q;
        pat_d       = pat_q;
        len_d       = len_q;
        thresh_d    = thresh_q;
        stop_pend_d = stop_pend_q;
        ready       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d       = cfg_pat;
                    len_d       = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
                    thresh_d    = cfg_thresh;
                    stop_pend_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (stop || stop_pend_q) begin
                    state_d = DONE;
                end else begin
                    ready = 1'b1;
                    if (in_if.in_valid) begin
                        byte_d    = in_if.in_data;
                        bit_idx_d = IDX_W'(BYTE_W - 1);
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (stop) stop_pend_d = 1'b1;
                bit_idx_d = bit_idx_q - 1'b1;
                if (bit_idx_q == '0) begin
                    state_d = (stop_pend_q || stop || thresh_hit) ? DONE : LOAD;
                end
            end
            DONE: begin
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_d = irq_q;
        if (irq_clr || start_acc) irq_d = 1'b0;
        if (state_q == DONE)      irq_d = 1'b1;
    end

    assign in_if.in_ready = ready;
    assign match_cnt      = cnt_q;
    assign busy           = (state_q == LOAD) || (state_q == SHIFT);
    assign done           = (state_q == DONE);
    assign irq            = irq_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: overlap, cross-byte, threshold, length edges, stop, reset, irq.
module tb_seq_scan_ctrl;
    import seq_ctrl_pkg::*;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int LEN_W = 3;

    logic             clk, rst, start, stop, irq_clr;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_thresh;
    logic             det_pulse, busy, done, irq;
    logic [CNT_W-1:0] match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    seq_scan_ctrl_if bus ();

    seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .irq_clr    (irq_clr),
        .cfg_pat    (cfg_pat),
        .cfg_len    (cfg_len),
        .cfg_thresh (cfg_thresh),
        .in_if      (bus),
        .det_pulse  (det_pulse),
        .match_cnt  (match_cnt),
        .busy       (busy),
        .done       (done),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                            input logic [CNT_W-1:0] t);
        cfg_pat = p; cfg_len = l; cfg_thresh = t;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Must be called in LOAD; returns det_pulse seen after each of the 8 shift edges.
    task automatic send_byte(input logic [7:0] data, output logic [7:0] dets);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            dets[i] = det_pulse;
        end
    endtask

    task automatic finish_scan();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, irq, det_pulse, bus.in_ready, match_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b irq=%b det=%b rdy=%b cnt=%0d, want all 0",
                     busy, done, irq, det_pulse, bus.in_ready, match_cnt);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_overlap();
        logic [7:0] d;
        do_start(4'b1011, 3'd4, 8'd0);
        cfg_pat = 4'b0000; cfg_len = 3'd0;
        n_checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_state: got busy=%b rdy=%b, want 1 1", busy, bus.in_ready);
        end
        send_byte(8'hB6, d);
        n_checks++;
        if (d !== 8'b0100_1000) begin
            n_fail++;
            $display("FAIL overlap_dets: got %b, want 01001000", d);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_done: got done=%b busy=%b, want 1 0", done, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || irq !== 1'b1 || match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_end: got done=%b irq=%b cnt=%0d, want 0 1 2", done, irq, match_cnt);
        end
    endtask

    task automatic test_cross_byte();
        logic [7:0] d1, d2;
        do_start(4'b1011, 3'd4, 8'd0);
        n_checks++;
        if (irq !== 1'b0 || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL start_clears: got irq=%b cnt=%0d, want 0 0", irq, match_cnt);
        end
        send_byte(8'h05, d1);
        send_byte(8'h80, d2);
        n_checks++;
        if (d1 !== 8'h00 || d2 !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL cross_dets: got %b %b, want 00000000 00000001", d1, d2);
        end
        finish_scan();
        n_checks++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL cross_cnt: got %0d, want 1", match_cnt);
        end
    endtask

    task automatic test_threshold();
        logic       rdy_seen;
        logic [7:0] cnt7;
        rdy_seen = 1'b0;
        cnt7     = '0;
        do_start(4'b1011, 3'd4, 8'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB6;
        tick();
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7) rdy_seen = rdy_seen | bus.in_ready;
            if (i == 6) cnt7 = match_cnt;
        end
        n_checks++;
        if (cnt7 !== 8'd2) begin
            n_fail++;
            $display("FAIL thresh_cnt7: got %0d, want 2", cnt7);
        end
        n_checks++;
        if (done !== 1'b1 || match_cnt !== 8'd2 || bus.in_ready !== 1'b0 || rdy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_done: got done=%b cnt=%0d rdy=%b seen=%b, want 1 2 0 0",
                     done, match_cnt, bus.in_ready, rdy_seen);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_idle: got busy=%b rdy=%b done=%b, want 0 0 0", busy, bus.in_ready, done);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_len_edges();
        logic [7:0] d;
        do_start(4'b1111, 3'd0, 8'd0);
        send_byte(8'hFF, d);
        send_byte(8'hFF, d);
        finish_scan();
        n_checks++;
        if (match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL len0_cnt: got %0d, want 0", match_cnt);
        end
        do_start(4'b1111, 3'd7, 8'd0);
        send_byte(8'hFF, d);
        n_checks++;
        if (d !== 8'b1111_1000) begin
            n_fail++;
            $display("FAIL clamp_dets: got %b, want 11111000", d);
        end
        finish_scan();
        n_checks++;
        if (match_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL clamp_cnt: got %0d, want 5", match_cnt);
        end
    endtask

    task automatic test_stall_stop();
        logic       stall_ok;
        logic [7:0] d;
        stall_ok = 1'b1;
        do_start(4'b1011, 3'd4, 8'd0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            if (busy !== 1'b1 || bus.in_ready !== 1'b1) stall_ok = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (stall_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_load: got ok=%b, want 1", stall_ok);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB6;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            stop = (i == 2);
            tick();
            d[i] = det_pulse;
        end
        stop = 1'b0;
        n_checks++;
        if (d !== 8'b0100_1000 || done !== 1'b1 || match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL stop_shift: got dets=%b done=%b cnt=%0d, want 01001000 1 2", d, done, match_cnt);
        end
        tick();
        do_start(4'b1011, 3'd4, 8'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB6;
        stop = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_load_rdy: got %b, want 0", bus.in_ready);
        end
        tick();
        stop = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL stop_load_done: got done=%b cnt=%0d, want 1 0", done, match_cnt);
        end
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_irq();
        logic [7:0] d;
        do_start(4'b1011, 3'd4, 8'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB6;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (det_pulse !== 1'b1 || match_cnt !== 8'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got det=%b cnt=%0d busy=%b, want 1 1 1", det_pulse, match_cnt, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, irq, det_pulse, bus.in_ready, match_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b irq=%b det=%b rdy=%b cnt=%0d, want all 0",
                     busy, done, irq, det_pulse, bus.in_ready, match_cnt);
        end
        #2;
        rst = 1'b0;
        tick();
        do_start(4'b1011, 3'd4, 8'd0);
        send_byte(8'hB6, d);
        n_checks++;
        if (d !== 8'b0100_1000) begin
            n_fail++;
            $display("FAIL post_reset_dets: got %b, want 01001000", d);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        n_checks++;
        if (irq !== 1'b1 || match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL irq_set_wins: got irq=%b cnt=%0d, want 1 2", irq, match_cnt);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clr: got %b, want 0", irq);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        cfg_pat = '0; cfg_len = '0; cfg_thresh = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_overlap();
        test_cross_byte();
        test_threshold();
        test_len_edges();
        test_stall_stop();
        test_reset_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Scan controller for a programmable serial pattern matcher.
- Accepts bytes over a valid/ready handshake and serialises each byte MSB-first, one bit per cycle, into a history shift register.
- Counts pattern matches, with overlapping matches allowed.
- Ends a scan on a match threshold or on an explicit stop, then raises an interrupt. Sits between a byte-stream source and CPU-visible status/irq logic.

Parameters:
- PAT_W, 4, maximum pattern length in bits and history register width.
- CNT_W, 8, match counter width.
- LEN_W, $clog2(PAT_W)+1, width of the pattern-length config.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begins a scan when idle.
- stop  in  1  pulse; requests an end of scan.
- irq_clr  in  1  clears sticky irq.
- cfg_pat  in  PAT_W  pattern; bit 0 is the most recent bit.
- cfg_len  in  LEN_W  pattern length.
- cfg_thresh  in  CNT_W  auto-stop match count; 0 disables auto-stop.
- in_valid  in  1  byte valid.
- in_data  in  8  byte, MSB scanned first.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- det_pulse  out  1  one-cycle match strobe.
- match_cnt  out  CNT_W  matches counted this scan.
- busy  out  1  scan in progress.
- done  out  1  one-cycle end-of-scan strobe.
- irq  out  1  sticky end-of-scan flag.

Behaviour:
- Reset (async, active-high): state IDLE. History, fill counter and bit index are cleared. in_ready=0, det_pulse=0, match_cnt=0, busy=0, done=0, irq=0.
- IDLE:
  - start → latch cfg_pat, cfg_len (clamped to PAT_W if larger) and cfg_thresh; clear history, fill count and match_cnt; clear irq; go to LOAD.
  - Config changes after start have no effect until the next start.
- LOAD:
  - in_ready=1, busy=1.
  - On handshake: capture the byte, bit_idx=7, go to SHIFT.
  - stop, or stop_pend set → DONE; no byte is accepted in that cycle.
- SHIFT (one bit per cycle):
  - history <= {history[PAT_W-2:0], byte[bit_idx]}; fill counter increments and saturates at PAT_W.
  - After bit 0: go to LOAD, or to DONE if stop_pend is set or the auto-stop condition is met.
  - Throughput is 9 cycles per byte.
- Match rule, evaluated on the post-shift history:
  - low cfg_len bits of history == low cfg_len bits of cfg_pat, and fill >= cfg_len, and cfg_len != 0.
  - det_pulse is registered: high in the cycle after the SHIFT cycle that consumed the completing bit.
  - match_cnt increments on the same edge and saturates at all-ones.
- Overlap: history is not cleared on a match. History persists across byte boundaries within a scan.
- stop during SHIFT: sets stop_pend. The current byte finishes and is fully counted, then DONE.
- Auto-stop: when match_cnt reaches a nonzero cfg_thresh, the current byte still finishes. Further matches in that byte are still counted. Then DONE.
- DONE: lasts one cycle. done=1, irq<=1, busy=0, then IDLE. match_cnt holds until the next start.
- irq: sticky; cleared by irq_clr in any state or by an accepted start. If a set and irq_clr coincide, the set wins.
- start while busy: ignored. stop while IDLE: ignored.
- Reset mid-scan: everything returns to reset values immediately. A partially shifted byte is discarded.

Decomposition:
- Shared package seq_ctrl_pkg: state enum {IDLE, LOAD, SHIFT, DONE}, localparam BYTE_W=8, default PAT_W/CNT_W.
- One sub-module, seq_match: history shift register, fill counter, length-masked comparator, and registered det_pulse. Controlled by shift_en/clear from the FSM.

Test Plan:
1. Overlap within a byte: cfg_pat=4'b1011, len=4, thresh=0, byte 0xB6, then stop.
   Required: det_pulse after the 4th and 7th bits, match_cnt=2, done, irq=1.
2. Cross-byte match: bytes 0x05 then 0x80, same pattern.
   Required: exactly one det_pulse, after the first bit of the second byte; match_cnt=1.
3. Threshold: thresh=2, byte 0xB6 then 0xFF offered with in_valid held high.
   Required: DONE after bit 0 of 0xB6, match_cnt=2, 0xFF never accepted (in_ready stays 0).
4. Length edge cases: cfg_len=0 with bytes 0xFF,0xFF → match_cnt=0.
   cfg_len=7 clamps to 4, pattern 4'b1111, byte 0xFF → 5 matches.
5. Handshake stall and stop: in_valid low for 5 cycles in LOAD → no shift, busy=1.
   stop mid-SHIFT → byte completes, then done.
   stop in LOAD → done the next cycle.
6. Reset and irq: assert rst during SHIFT → all outputs 0 asynchronously, then a fresh start succeeds.
   irq_clr on the same cycle as DONE → irq=1 (set wins).
